// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: arbitrates three 6-bit sources by fixed priority, converts
// the winner to tens/units with a subtract-by-10 FSM, and time-multiplexes the
// two BCD digits onto one 4-bit output using a prescaled scan counter.
// Optional build macro: DISP_SCAN_BLANK_LEADING_EN (blank a zero tens digit
// with 4'hF).
module disp_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned CNT_W    = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [5:0] x,
  input  logic [5:0] y,
  input  logic [5:0] z,
  output logic [1:0] sel,
  output logic [3:0] digit,
  output logic [1:0] src,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StLoad, StSub, StCommit} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       digit_q, digit_d;
  logic [1:0]       src_q, src_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       units_q, units_d;
  logic [5:0]       rem_q, rem_d;
  logic [3:0]       tens_n_q, tens_n_d;
  logic [1:0]       src_n_q, src_n_d;
  logic             skip_q, skip_d;
  logic             en_q;

  logic wrap;
  logic start;

  assign wrap  = en && (cnt_q == CNT_W'(SCAN_DIV - 1));
  // Rising enable or the end of the tens phase (frame boundary) kicks a conversion.
  assign start = en && (!en_q || (wrap && (sel_q == 2'b01)));

  // Prescaler and digit-select scan.
  always_comb begin
    cnt_d = cnt_q;
    sel_d = sel_q;
    if (!en) begin
      cnt_d = '0;
      sel_d = 2'b00;
    end else if (wrap) begin
      cnt_d = '0;
      sel_d = (sel_q == 2'b01) ? 2'b00 : 2'b01;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Conversion FSM next-state and result registers.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    tens_n_d = tens_n_q;
    src_n_d  = src_n_q;
    skip_d   = skip_q;
    tens_d   = tens_q;
    units_d  = units_q;
    src_d    = src_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          skip_d = 1'b0;
          if (x != 6'd0) begin
            rem_d   = x;
            src_n_d = 2'b00;
          end else if (y != 6'd0) begin
            rem_d   = y;
            src_n_d = 2'b01;
          end else begin
            src_n_d = 2'b10;
            // Legacy datapath truncates z to its low nibble when it exceeds 9.
            if (z > 6'd9) begin
              rem_d  = {2'b00, z[3:0]};
              skip_d = 1'b1;
            end else begin
              rem_d = z;
            end
          end
          state_d = StLoad;
        end
      end
      StLoad: begin
        tens_n_d = 4'd0;
        state_d  = skip_q ? StCommit : StSub;
      end
      StSub: begin
        if (rem_q >= 6'd10) begin
          rem_d    = rem_q - 6'd10;
          tens_n_d = tens_n_q + 4'd1;
        end else begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        tens_d  = tens_n_q;
        units_d = rem_q[3:0];
        src_d   = src_n_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Dropping enable abandons any conversion without touching the result.
    if (!en) begin
      state_d = StIdle;
      tens_d  = tens_q;
      units_d = units_q;
      src_d   = src_q;
    end
  end

  // Digit mux, registered so it moves together with sel.
  always_comb begin
    digit_d = 4'd0;
    if (en) begin
      if (sel_d == 2'b01) begin
`ifdef DISP_SCAN_BLANK_LEADING_EN
        digit_d = (tens_d == 4'd0) ? 4'hF : tens_d;
`else
        digit_d = tens_d;
`endif
      end else begin
        digit_d = units_d;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sel_q    <= 2'b00;
      digit_q  <= 4'd0;
      src_q    <= 2'b11;
      tens_q   <= 4'd0;
      units_q  <= 4'd0;
      rem_q    <= 6'd0;
      tens_n_q <= 4'd0;
      src_n_q  <= 2'b11;
      skip_q   <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      digit_q  <= digit_d;
      src_q    <= src_d;
      tens_q   <= tens_d;
      units_q  <= units_d;
      rem_q    <= rem_d;
      tens_n_q <= tens_n_d;
      src_n_q  <= src_n_d;
      skip_q   <= skip_d;
      en_q     <= en;
    end
  end

  assign sel   = sel_q;
  assign digit = digit_q;
  assign src   = src_q;
  assign busy  = (state_q != StIdle);

endmodule
